// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU bit-slice datapath.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_PASSB = 3'b000;
    localparam alu_op_t OP_RSV1  = 3'b001;
    localparam alu_op_t OP_ADD   = 3'b010;
    localparam alu_op_t OP_SUB   = 3'b011;
    localparam alu_op_t OP_AND   = 3'b100;
    localparam alu_op_t OP_OR    = 3'b101;
    localparam alu_op_t OP_XOR   = 3'b110;
    localparam alu_op_t OP_RSV7  = 3'b111;

endpackage

// File: rtl/alu_bit_slice_comb.sv
// Combinational 1-bit ALU slice: adder with optional B inversion plus logic ops.
module alu_bit_slice_comb
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_t cntrl,
    output logic    result,
    output logic    cout
);

    logic       b_eff_s;
    logic       sum_s;
    logic [7:0] mux_in_s;

    // cntrl[0] inverts B for every opcode, so cout follows it even in logic ops
    mux2_1 u_bmux (
        .in  ({~b, b}),
        .sel (cntrl[0]),
        .out (b_eff_s)
    );

    full_adder u_fa (
        .a    (a),
        .b    (b_eff_s),
        .cin  (cin),
        .sum  (sum_s),
        .cout (cout)
    );

    // Opcode-indexed inputs to the result mux; reserved codes read as zero
    always_comb begin
        mux_in_s           = 8'h00;
        mux_in_s[OP_PASSB] = b;
        mux_in_s[OP_RSV1]  = 1'b0;
        mux_in_s[OP_ADD]   = sum_s;
        mux_in_s[OP_SUB]   = sum_s;
        mux_in_s[OP_AND]   = a & b;
        mux_in_s[OP_OR]    = a | b;
        mux_in_s[OP_XOR]   = a ^ b;
        mux_in_s[OP_RSV7]  = 1'b0;
    end

    mux8_1 u_omux (
        .in  (mux_in_s),
        .sel (cntrl),
        .out (result)
    );

endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/mux2_1.sv
// Two-input one-bit multiplexer: out = in[sel].
module mux2_1 (
    input  logic [1:0] in,
    input  logic       sel,
    output logic       out
);

    // Select one of the two inputs
    always_comb begin
        if (sel) begin
            out = in[1];
        end else begin
            out = in[0];
        end
    end

endmodule

// File: rtl/mux8_1.sv
// Eight-input one-bit multiplexer: out = in[sel].
module mux8_1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    // Select one of the eight inputs
    always_comb begin
        case (sel)
            3'd0:    out = in[0];
            3'd1:    out = in[1];
            3'd2:    out = in[2];
            3'd3:    out = in[3];
            3'd4:    out = in[4];
            3'd5:    out = in[5];
            3'd6:    out = in[6];
            3'd7:    out = in[7];
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_bit_slice_core.sv
// Registered ripple-carry ALU built from WIDTH combinational bit slices.
module alu_bit_slice_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_bit_slice_comb u_slice (
            .a      (a[i]),
            .b      (b[i]),
            .cin    (carry_s[i]),
            .cntrl  (cntrl),
            .result (result_s[i]),
            .cout   (carry_s[i+1])
        );
    end

    // Output registers; reset is active low and clears them immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else begin
            result_r <= result_s;
            cout_r   <= carry_s[WIDTH];
        end
    end

    assign result = result_r;
    assign cout   = cout_r;

endmodule

// File: tb/tb_alu_bit_slice_core.sv
// Scoreboard bench driving a 1-bit and an 8-bit instance side by side.
module tb_alu_bit_slice_core;

    typedef struct {
        string      tag;
        logic [7:0] r8;
        logic       c8;
        logic       r1;
        logic       c1;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       cin;
    logic [2:0] cntrl;
    logic [7:0] a8, b8, result8;
    logic       cout8;
    logic [0:0] a1, b1, result1;
    logic       cout1;

    int   checks;
    int   errors;
    exp_t sb[$];

    alu_bit_slice_core #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .a      (a1),
        .b      (b1),
        .cin    (cin),
        .cntrl  (cntrl),
        .result (result1),
        .cout   (cout1)
    );

    alu_bit_slice_core #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .a      (a8),
        .b      (b8),
        .cin    (cin),
        .cntrl  (cntrl),
        .result (result8),
        .cout   (cout8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: bit 8 = carry out of bit w-1, bits 7:0 = result
    function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic [2:0] op);
        logic [7:0] mask;
        logic [7:0] am;
        logic [7:0] bm;
        logic [7:0] bb;
        logic [8:0] s;
        logic [7:0] r;
        logic       carry;
        mask  = (w == 8) ? 8'hFF : 8'h01;
        am    = a & mask;
        bm    = b & mask;
        bb    = (op[0] ? ~bm : bm) & mask;
        s     = {1'b0, am} + {1'b0, bb} + {8'd0, c};
        carry = (w == 8) ? s[8] : s[1];
        case (op)
            3'b000:  r = bm;
            3'b010:  r = s[7:0];
            3'b011:  r = s[7:0];
            3'b100:  r = am & bm;
            3'b101:  r = am | bm;
            3'b110:  r = am ^ bm;
            default: r = 8'h00;
        endcase
        return {carry, r & mask};
    endfunction

    task automatic step(input string tag, input logic [7:0] a8v, input logic [7:0] b8v,
                        input logic a1v, input logic b1v, input logic cv, input logic [2:0] opv);
        exp_t       e;
        exp_t       g;
        logic [8:0] m8;
        logic [8:0] m1;
        a8    = a8v;
        b8    = b8v;
        a1    = a1v;
        b1    = b1v;
        cin   = cv;
        cntrl = opv;
        m8    = model(8, a8v, b8v, cv, opv);
        m1    = model(1, {7'd0, a1v}, {7'd0, b1v}, cv, opv);
        e.tag = tag;
        e.r8  = m8[7:0];
        e.c8  = m8[8];
        e.r1  = m1[0];
        e.c1  = m1[8];
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({g.tag, ".r8"}, result8, g.r8);
        chk({g.tag, ".c8"}, {7'd0, cout8}, {7'd0, g.c8});
        chk({g.tag, ".r1"}, {7'd0, result1}, {7'd0, g.r1});
        chk({g.tag, ".c1"}, {7'd0, cout1}, {7'd0, g.c1});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        a1     = 1'b1;
        b1     = 1'b1;
        a8     = 8'h01;
        b8     = 8'h01;
        cin    = 1'b0;
        cntrl  = 3'b010;

        // Held in reset while clocking: outputs stay cleared
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst.r1", {7'd0, result1}, 8'h00);
            chk("rst.c1", {7'd0, cout1}, 8'h00);
            chk("rst.r8", result8, 8'h00);
            chk("rst.c8", {7'd0, cout8}, 8'h00);
        end
        reset = 1'b1;
        step("rel", 8'h01, 8'h01, 1'b1, 1'b1, 1'b0, 3'b010);
        chk("rel.c1_const", {7'd0, cout1}, 8'h01);

        // Exhaustive 1-bit sweep; 8-bit instance gets random operands
        for (int v = 0; v < 64; v++) begin
            logic [5:0] vv;
            vv = v[5:0];
            step("sweep", 8'($urandom), 8'($urandom), vv[5], vv[4], vv[3], vv[2:0]);
        end

        step("add7f", 8'h7F, 8'h01, 1'b1, 1'b1, 1'b0, 3'b010);
        chk("add7f.const", result8, 8'h80);
        step("addff", 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 3'b010);
        chk("addff.cout", {7'd0, cout8}, 8'h01);
        step("sub57", 8'h05, 8'h07, 1'b1, 1'b1, 1'b1, 3'b011);
        chk("sub57.const", result8, 8'hFE);
        step("sub75", 8'h07, 8'h05, 1'b1, 1'b1, 1'b1, 3'b011);
        chk("sub75.const", result8, 8'h02);
        step("subnc", 8'h07, 8'h05, 1'b0, 1'b1, 1'b0, 3'b011);
        step("and", 8'hA5, 8'h0F, 1'b1, 1'b0, 1'b0, 3'b100);
        chk("and.const", result8, 8'h05);

        // Asynchronous reset between edges clears a nonzero result at once
        step("load", 8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 3'b101);
        chk("load.nz", {7'd0, (result8 != 8'h00)}, 8'h01);
        reset = 1'b0;
        #2;
        chk("async.r8", result8, 8'h00);
        chk("async.c8", {7'd0, cout8}, 8'h00);
        chk("async.r1", {7'd0, result1}, 8'h00);
        chk("async.c1", {7'd0, cout1}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("recov", 8'hC3, 8'h3C, 1'b0, 1'b1, 1'b1, 3'b110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_bit_slice_core.md
Name: alu_bit_slice_core

Overview:
- Registered ALU slice of configurable width, built as a ripple chain of 1-bit slices.
- Each slice is a full adder with optional B inversion plus AND/OR/XOR/pass-B logic, selected by a 3-bit opcode through an 8:1 mux.
- Used as the per-bit datapath element of the single-cycle CPU ALU; the default configuration is one bit.
- Outputs are captured in flops on the clock edge to give the integrating ALU a clean timing boundary.

Parameters:
- WIDTH, 1, number of bit slices in the ripple chain (1..64).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all output registers.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0. Caller drives 1 for subtraction.
- cntrl  input  3  opcode.
- result  output  WIDTH  registered operation result.
- cout  output  1  registered carry out of the MSB adder.

Behaviour:
- Opcode map, applied bitwise per slice:
  - 000: result = b
  - 001: result = 0 (reserved)
  - 010: result = a + b + cin
  - 011: result = a + ~b + cin
  - 100: result = a & b
  - 101: result = a | b
  - 110: result = a ^ b
  - 111: result = 0 (reserved)
- Adder B-input mux: select = cntrl[0]; chooses ~b when 1, b when 0.
  - This rule holds for all opcodes, not only 010/011.
- Ripple carry: slice i's carry-in is slice i-1's carry-out; slice 0 takes cin.
- cout is the MSB adder carry-out, computed for every opcode and registered even during logic ops. Consumers must ignore it outside 010/011.
- Arithmetic is modulo 2^WIDTH; no overflow flag.
- Subtraction is two's complement only when cin = 1. With cin = 0 the result is a - b - 1; this is not corrected.
- Latency:
  - Combinational next-state from a, b, cin, cntrl.
  - result and cout update on every rising clk edge.
  - One cycle of latency; no enable and no handshake.
- Reset:
  - While reset = 0, result = 0 and cout = 0 immediately, independent of clk.
  - On release, the first rising edge loads normal values.
  - Reset asserted mid-operation discards the pending value.
- No X propagation from reserved opcodes; they produce 0.
- Gate-level delays are not required; zero-delay RTL is acceptable.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_PASSB = 3'b000, OP_ADD = 3'b010, OP_SUB = 3'b011, OP_AND = 3'b100, OP_OR = 3'b101, OP_XOR = 3'b110.
  - typedef alu_op_t as logic [2:0].
- Leaf sub-modules:
  - full_adder: a, b, cin -> sum, cout.
  - mux2_1: 2-bit in, sel -> out.
  - mux8_1: 8-bit in, 3-bit sel -> out. in[sel] is the output.
- Natural single sub-module: alu_bit_slice_comb, the combinational 1-bit slice.
  - Instantiates one full_adder, one mux2_1 and one mux8_1.
  - Generate-replicated WIDTH times; the top adds the output registers.

Test Plan:
- WIDTH=1, hold reset=0, drive a=1,b=1,cntrl=010 and toggle clk -> result=0, cout=0 throughout reset. Release reset, one edge -> result=0, cout=1.
- WIDTH=1, exhaustive sweep of {a,b,cin,cntrl} over 0..63, checked one cycle after each vector:
  - 000 -> result=b.
  - 010 -> result=a^b^cin, cout=majority(a,b,cin).
  - 011 -> result=a^~b^cin, cout=majority(a,~b,cin).
  - 100/101/110 -> result=a&b, a|b, a^b respectively.
  - 001/111 -> result=0.
- WIDTH=8, a=0x7F, b=0x01, cin=0, cntrl=010 -> next edge result=0x80, cout=0. Then a=0xFF, b=0x01 -> result=0x00, cout=1.
- WIDTH=8, a=0x05, b=0x07, cin=1, cntrl=011 -> result=0xFE, cout=0. Then a=0x07, b=0x05 -> result=0x02, cout=1.
- WIDTH=8, cntrl=100, a=0xA5, b=0x0F, cin=0 -> result=0x05. Also check cout is registered adder carry, here 0 because cntrl[0]=0.
- WIDTH=8, result loaded with a nonzero value, then reset pulsed low between edges -> result=0x00 and cout=0 asynchronously, before the next clk edge.
